// File: rtl/fault_responder.sv
// Purpose: turns posit-checker reports into delivered sums, recomputing after faults and keeping fault statistics.
// Latency: out_valid 1 cycle after a clean accept, RECOMP_LAT+1 cycles after a faulted accept.
// Backpressure: in_ready only in IDLE; the result is held in OUTPUT until out_ready, so throughput is at most 1 report per 2 cycles.
module fault_responder #(
  parameter int FULL_NBITS   = 32,
  parameter int TRUNC_NBITS  = 16,
  parameter int RECOMP_LAT   = 4,
  parameter int ALARM_THRESH = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  fault,
  input  logic                  mode,
  input  logic [FULL_NBITS-1:0] true_sum,
  input  logic [FULL_NBITS-1:0] used_sum,
  input  logic [6:0]            true_scale,
  input  logic [6:0]            used_scale,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULL_NBITS-1:0] out_sum,
  output logic                  out_corrected,
  output logic                  out_mode,
  output logic [CNT_W-1:0]      op_count,
  output logic [CNT_W-1:0]      fault_count,
  output logic [CNT_W-1:0]      consec_faults,
  output logic [6:0]            max_delta,
  output logic                  alarm,
  input  logic                  alarm_clr
);

  localparam int TRUNC_SHIFT = FULL_NBITS - TRUNC_NBITS;
  localparam int RC_W        = (RECOMP_LAT > 1) ? $clog2(RECOMP_LAT) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RECOMP_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECOMPUTE = 2'd1,
    OUTPUT    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [RC_W-1:0]         rc_cnt_q, rc_cnt_d;
  logic [FULL_NBITS-1:0]   out_sum_q, out_sum_d;
  logic                    out_corr_q, out_corr_d;
  logic                    out_mode_q, out_mode_d;
  logic [CNT_W-1:0]        op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]        flt_cnt_q, flt_cnt_d;
  logic [CNT_W-1:0]        consec_q, consec_d;
  logic [6:0]              max_delta_q, max_delta_d;
  logic                    alarm_q, alarm_d;

  logic                    accept;
  logic [6:0]              delta;
  logic [FULL_NBITS-1:0]   trunc_sum;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == OUTPUT);

  // Truncated checker result sits in the low bits; left-justify it into the full width.
  assign trunc_sum = used_sum << TRUNC_SHIFT;
  assign delta     = (true_scale >= used_scale) ? (true_scale - used_scale)
                                                : (used_scale - true_scale);

  // State register and recompute down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rc_cnt_q <= rc_cnt_d;
    end
  end

  // Next-state logic: clean reports go straight to OUTPUT, faulted ones wait RECOMP_LAT cycles.
  always_comb begin
    state_d  = state_q;
    rc_cnt_d = rc_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            state_d  = RECOMPUTE;
            rc_cnt_d = RC_LOAD;
          end else begin
            state_d  = OUTPUT;
          end
        end
      end
      RECOMPUTE: begin
        if (rc_cnt_q == '0) begin
          state_d = OUTPUT;
        end else begin
          rc_cnt_d = rc_cnt_q - 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        rc_cnt_d = '0;
      end
    endcase
  end

  // Result capture: everything delivered is latched at accept and held until the next accept.
  always_comb begin
    out_sum_d  = out_sum_q;
    out_corr_d = out_corr_q;
    out_mode_d = out_mode_q;
    if (accept) begin
      out_corr_d = fault;
      out_mode_d = mode;
      if (fault) begin
        out_sum_d = true_sum;
      end else if (mode) begin
        out_sum_d = trunc_sum;
      end else begin
        out_sum_d = used_sum;
      end
    end
  end

  // Statistics: saturating counters, running max scale delta, consecutive-fault run and alarm.
  always_comb begin
    op_cnt_d    = op_cnt_q;
    flt_cnt_d   = flt_cnt_q;
    max_delta_d = max_delta_q;
    consec_d    = consec_q;
    alarm_d     = alarm_q;
    if (alarm_clr) begin
      consec_d = '0;
      alarm_d  = 1'b0;
    end
    if (accept) begin
      if (op_cnt_q != CNT_MAX) begin
        op_cnt_d = op_cnt_q + 1'b1;
      end
      if (delta > max_delta_q) begin
        max_delta_d = delta;
      end
      if (fault) begin
        if (flt_cnt_q != CNT_MAX) begin
          flt_cnt_d = flt_cnt_q + 1'b1;
        end
        // A clear in the same cycle restarts the run at this fault.
        if (alarm_clr) begin
          consec_d = CNT_W'(1);
        end else if (consec_q != CNT_MAX) begin
          consec_d = consec_q + 1'b1;
        end
        if (consec_d >= THRESH_C) begin
          alarm_d = 1'b1;
        end
      end else begin
        consec_d = '0;
      end
    end
  end

  // Datapath and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_q   <= '0;
      out_corr_q  <= 1'b0;
      out_mode_q  <= 1'b0;
      op_cnt_q    <= '0;
      flt_cnt_q   <= '0;
      consec_q    <= '0;
      max_delta_q <= '0;
      alarm_q     <= 1'b0;
    end else begin
      out_sum_q   <= out_sum_d;
      out_corr_q  <= out_corr_d;
      out_mode_q  <= out_mode_d;
      op_cnt_q    <= op_cnt_d;
      flt_cnt_q   <= flt_cnt_d;
      consec_q    <= consec_d;
      max_delta_q <= max_delta_d;
      alarm_q     <= alarm_d;
    end
  end

  assign out_sum       = out_sum_q;
  assign out_corrected = out_corr_q;
  assign out_mode      = out_mode_q;
  assign op_count      = op_cnt_q;
  assign fault_count   = flt_cnt_q;
  assign consec_faults = consec_q;
  assign max_delta     = max_delta_q;
  assign alarm         = alarm_q;

endmodule

// File: tb/tb_fault_responder.sv
// Purpose: directed self-checking bench for fault_responder with default parameters.
// Latency: checks the 1-cycle clean and RECOMP_LAT+1-cycle faulted delivery timing.
// Backpressure: holds out_ready low to verify the result stays stable while stalled.
module tb_fault_responder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        fault;
  logic        mode;
  logic [31:0] true_sum;
  logic [31:0] used_sum;
  logic [6:0]  true_scale;
  logic [6:0]  used_scale;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_corrected;
  logic        out_mode;
  logic [15:0] op_count;
  logic [15:0] fault_count;
  logic [15:0] consec_faults;
  logic [6:0]  max_delta;
  logic        alarm;
  logic        alarm_clr;

  int n_assert = 0;
  int n_fail   = 0;

  fault_responder #(
    .FULL_NBITS(32), .TRUNC_NBITS(16), .RECOMP_LAT(4), .ALARM_THRESH(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fault(fault), .mode(mode),
    .true_sum(true_sum), .used_sum(used_sum),
    .true_scale(true_scale), .used_scale(used_scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_corrected(out_corrected), .out_mode(out_mode),
    .op_count(op_count), .fault_count(fault_count), .consec_faults(consec_faults),
    .max_delta(max_delta), .alarm(alarm), .alarm_clr(alarm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one report for exactly one cycle (it is accepted on that edge when in_ready).
  task automatic send(input logic f, input logic m, input logic [31:0] ts, input logic [31:0] us,
                      input logic [6:0] tsc, input logic [6:0] usc);
    in_valid   = 1'b1;
    fault      = f;
    mode       = m;
    true_sum   = ts;
    used_sum   = us;
    true_scale = tsc;
    used_scale = usc;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int          stray;

    rst_n = 1'b0; in_valid = 1'b0; fault = 1'b0; mode = 1'b0;
    true_sum = '0; used_sum = '0; true_scale = '0; used_scale = '0;
    out_ready = 1'b0; alarm_clr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_alarm", {31'd0, alarm}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Clean full-width report
    send(1'b0, 1'b0, 32'h1234_5678, 32'h4000_0000, 7'd3, 7'd5);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_sum", out_sum, 32'h4000_0000);
    chk("full_corrected", {31'd0, out_corrected}, 32'd0);
    chk("full_op_count", {16'd0, op_count}, 32'd1);
    chk("full_max_delta", {25'd0, max_delta}, 32'd2);
    deliver();
    chk("full_done_valid", {31'd0, out_valid}, 32'd0);

    // Clean truncated report
    send(1'b0, 1'b1, 32'h0, 32'h0000_4A00, 7'd4, 7'd4);
    chk("trunc_out_sum", out_sum, 32'h4A00_0000);
    chk("trunc_out_mode", {31'd0, out_mode}, 32'd1);
    chk("trunc_op_count", {16'd0, op_count}, 32'd2);
    deliver();

    // Faulted report: 4 recompute cycles, plus a stray in_valid that must be ignored
    send(1'b1, 1'b1, 32'h3C00_0000, 32'h1111_1111, 7'd9, 7'd2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fault_wait%0d_valid", i), {31'd0, out_valid}, 32'd0);
      if (i == 1) begin
        in_valid = 1'b1; fault = 1'b0; used_sum = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("fault_out_valid", {31'd0, out_valid}, 32'd1);
    chk("fault_out_sum", out_sum, 32'h3C00_0000);
    chk("fault_corrected", {31'd0, out_corrected}, 32'd1);
    chk("fault_fault_count", {16'd0, fault_count}, 32'd1);
    chk("fault_op_count", {16'd0, op_count}, 32'd3);
    chk("fault_max_delta", {25'd0, max_delta}, 32'd7);
    chk("fault_consec", {16'd0, consec_faults}, 32'd1);
    deliver();

    // Clean report with used_scale > true_scale breaks the run and widens max_delta
    send(1'b0, 1'b0, 32'h0, 32'h0000_0001, 7'd0, 7'd100);
    chk("abs_max_delta", {25'd0, max_delta}, 32'd100);
    chk("abs_consec", {16'd0, consec_faults}, 32'd0);
    deliver();

    // Three stalled faulted reports raise the alarm on the third accept
    for (int k = 1; k <= 3; k++) begin
      send(1'b1, 1'b0, 32'h5000_0000 + k, 32'h0, 7'd10, 7'd10);
      chk($sformatf("bp%0d_consec", k), {16'd0, consec_faults}, k);
      chk($sformatf("bp%0d_alarm", k), {31'd0, alarm}, (k >= 3) ? 32'd1 : 32'd0);
      repeat (4) tick();
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("bp%0d_stall%0d_valid", k, s), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp%0d_stall%0d_sum", k, s), out_sum, 32'h5000_0000 + k);
        tick();
      end
      deliver();
    end
    chk("bp_fault_count", {16'd0, fault_count}, 32'd4);
    chk("bp_op_count", {16'd0, op_count}, 32'd7);

    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    chk("clr_alarm", {31'd0, alarm}, 32'd0);
    chk("clr_consec", {16'd0, consec_faults}, 32'd0);

    // Clear coincident with a faulted accept restarts the run at 1 without alarm
    alarm_clr = 1'b1;
    send(1'b1, 1'b0, 32'h0000_0042, 32'h0, 7'd1, 7'd1);
    alarm_clr = 1'b0;
    chk("clrf_consec", {16'd0, consec_faults}, 32'd1);
    chk("clrf_alarm", {31'd0, alarm}, 32'd0);
    repeat (4) tick();
    chk("clrf_out_sum", out_sum, 32'h0000_0042);
    deliver();

    // Reset in the middle of RECOMPUTE discards the pending result
    send(1'b1, 1'b0, 32'h7777_0000, 32'h0, 7'd50, 7'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_sum", out_sum, 32'd0);
    chk("mid_rst_corrected", {31'd0, out_corrected}, 32'd0);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_fault_count", {16'd0, fault_count}, 32'd0);
    chk("mid_rst_max_delta", {25'd0, max_delta}, 32'd0);
    chk("mid_rst_consec", {16'd0, consec_faults}, 32'd0);
    tick();
    rst_n = 1'b1;
    stray = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stray++;
    end
    out_ready = 1'b0;
    chk("post_rst_no_valid", stray, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    send(1'b0, 1'b0, 32'h0, 32'h1234_0000, 7'd2, 7'd0);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    held = out_sum;
    chk("post_rst_out_sum", held, 32'h1234_0000);
    chk("post_rst_op_count", {16'd0, op_count}, 32'd1);
    deliver();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_responder.md
FAULT_RESPONDER -- requirements
Module: fault_responder

Interface
REQ-001 SHALL have parameter FULL_NBITS, default 32, full posit width.
REQ-002 SHALL have parameter TRUNC_NBITS, default 16, truncated-checker posit width.
REQ-003 SHALL have parameter RECOMP_LAT, default 4, cycles spent in RECOMPUTE (>=1).
REQ-004 SHALL have parameter ALARM_THRESH, default 3, consecutive faults that raise alarm (>=1).
REQ-005 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-006 SHALL have one clock and an asynchronous active-low reset, with ports listed below.
REQ-007 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  checker report valid
- in_ready  out  1  responder can accept a report
- fault  in  1  checker fault flag
- mode  in  1  1 = truncated adder used
- true_sum  in  FULL_NBITS  full-adder sum
- used_sum  in  FULL_NBITS  checker sum, low TRUNC_NBITS bits valid when mode=1
- true_scale  in  7  scale of true_sum
- used_scale  in  7  scale of used_sum
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  FULL_NBITS  delivered sum
- out_corrected  out  1  out_sum came from true_sum because of a fault
- out_mode  out  1  registered mode of the delivered report
- op_count  out  CNT_W  reports accepted
- fault_count  out  CNT_W  faulted reports accepted
- consec_faults  out  CNT_W  current run of consecutive faults
- max_delta  out  7  largest |true_scale - used_scale| seen
- alarm  out  1  sticky consecutive-fault alarm
- alarm_clr  in  1  clears alarm and consec_faults

Function
REQ-008 SHALL implement FSM states IDLE, RECOMPUTE, OUTPUT; reset state IDLE.
REQ-009 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready.
REQ-010 On accept with fault=0, the FSM SHALL go IDLE->OUTPUT; out_valid is high the cycle after accept.
REQ-011 On accept with fault=1, the FSM SHALL go IDLE->RECOMPUTE, stay exactly RECOMP_LAT cycles (down-counter), then enter OUTPUT; out_valid rises RECOMP_LAT+1 cycles after accept.
REQ-012 In OUTPUT, out_valid SHALL be 1 and out_sum/out_corrected/out_mode SHALL be held stable until out_ready=1; out_valid && out_ready SHALL return the FSM to IDLE on the next edge. There is no bypass, so throughput is at most one report per 2 cycles.
REQ-013 out_sum SHALL be:
- true_sum when fault=1;
- else {used_sum[TRUNC_NBITS-1:0], (FULL_NBITS-TRUNC_NBITS) zeros} when mode=1;
- else used_sum.
All three are captured at accept.
REQ-014 out_corrected SHALL equal the captured fault; out_mode SHALL equal the captured mode.
REQ-015 On every accept, op_count SHALL increment; on an accept with fault=1, fault_count SHALL increment. Both saturate at 2^CNT_W-1 and never wrap.
REQ-016 On every accept, max_delta SHALL update to max(max_delta, |true_scale - used_scale|), computed unsigned in 7 bits without wrap.
REQ-017 consec_faults SHALL increment (saturating) on a fault accept and clear to 0 on a non-fault accept.
REQ-018 alarm SHALL set on the edge where the post-update consec_faults >= ALARM_THRESH, and then stay set.
REQ-019 alarm_clr=1 SHALL clear alarm and consec_faults. If alarm_clr coincides with a fault accept, consec_faults SHALL become 1 and alarm SHALL set only if ALARM_THRESH=1. A non-fault accept together with alarm_clr SHALL give 0.
REQ-020 Inputs SHALL be ignored when not accepted; in_valid asserted outside IDLE SHALL have no effect.

Reset
REQ-021 rst_n=0 SHALL asynchronously force:
- state IDLE, RECOMPUTE counter 0;
- out_valid=0, out_sum=0, out_corrected=0, out_mode=0;
- all counters 0, max_delta=0, alarm=0;
- in_ready=1 once rst_n=1.
REQ-022 Reset mid-RECOMPUTE or mid-OUTPUT SHALL discard the pending result; no out_valid SHALL occur for it after release.

Verification
REQ-023 No-fault full: fault=0, mode=0, used_sum=0x40000000 -> out_valid the next cycle, out_sum=0x40000000, out_corrected=0, op_count=1.
REQ-024 No-fault truncated: mode=1, used_sum=0x00004A00 -> out_sum=0x4A000000, out_mode=1.
REQ-025 Fault: fault=1, true_sum=0x3C000000, true_scale=9, used_scale=2 -> out_valid 5 cycles after accept, out_sum=0x3C000000, out_corrected=1, fault_count=1, max_delta=7.
REQ-026 Backpressure/alarm: three fault reports with out_ready held 0 for 3 cycles each -> out_sum stable while stalled, alarm=1 after the third accept; alarm_clr pulse -> alarm=0, consec_faults=0.
REQ-027 rst_n low during RECOMPUTE -> all outputs 0 immediately, no out_valid after release, next report handled normally.
